// File: rtl/select_scanner.sv
// rtl/select_scanner.sv - ascending channel scanner driving a 3-to-8 decoder select/enable
module select_scanner #(
   parameter int DWELL = 4,
   parameter int GAP   = 1,
   parameter int CW    = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       mode,
   input  logic [7:0] mask,
   output logic [2:0] sel,
   output logic       en,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [1:0] {S_IDLE, S_DWELL, S_GAP} state_t;

   localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
   localparam logic [CW-1:0] GAP_LD   = CW'((GAP > 0) ? GAP - 1 : 0);

   state_t        state, state_nx;
   logic [7:0]    cap_mask, cap_mask_nx;
   logic          cap_mode, cap_mode_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    sel_nx;
   logic          en_nx, busy_nx, done_nx, err_nx;
   logic [3:0]    nxt;

   function automatic logic [2:0] lowest(input logic [7:0] m);
      lowest = '0;
      for (int i = 7; i >= 0; i--)
         if (m[i]) lowest = 3'(i);
   endfunction

   // {found, index}; offset 8 lands back on cur, reachable only when wrapping
   function automatic logic [3:0] next_ch(input logic [7:0] m, input logic [2:0] cur,
                                          input logic wrap);
      logic [3:0] idx;
      next_ch = '0;
      for (int i = 8; i >= 1; i--) begin
         idx = {1'b0, cur} + 4'(i);
         if ((wrap || !idx[3]) && m[idx[2:0]])
            next_ch = {1'b1, idx[2:0]};
      end
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         cap_mask <= '0;
         cap_mode <= 1'b0;
         cnt      <= '0;
         sel      <= '0;
         en       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nx;
         cap_mask <= cap_mask_nx;
         cap_mode <= cap_mode_nx;
         cnt      <= cnt_nx;
         sel      <= sel_nx;
         en       <= en_nx;
         busy     <= busy_nx;
         done     <= done_nx;
         err      <= err_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      cap_mask_nx = cap_mask;
      cap_mode_nx = cap_mode;
      cnt_nx      = cnt;
      sel_nx      = sel;
      done_nx     = 1'b0;
      err_nx      = 1'b0;
      nxt         = next_ch(cap_mask, sel, cap_mode);
      case (state)
         S_IDLE: begin
            if (start && !stop) begin
               if (mask != 8'h00) begin
                  cap_mask_nx = mask;
                  cap_mode_nx = mode;
                  sel_nx      = lowest(mask);
                  cnt_nx      = DWELL_LD;
                  state_nx    = S_DWELL;
               end else begin
                  err_nx = 1'b1;
               end
            end
         end
         S_DWELL: begin
            if (stop) begin
               state_nx = S_IDLE;
            end else if (cnt != '0) begin
               cnt_nx = cnt - CW'(1);
            end else if (nxt[3]) begin
               if (GAP > 0) begin
                  state_nx = S_GAP;
                  cnt_nx   = GAP_LD;
               end else begin
                  sel_nx = nxt[2:0];
                  cnt_nx = DWELL_LD;
               end
            end else begin
               state_nx = S_IDLE;
               done_nx  = 1'b1;
            end
         end
         S_GAP: begin
            if (stop) begin
               state_nx = S_IDLE;
            end else if (cnt != '0) begin
               cnt_nx = cnt - CW'(1);
            end else begin
               sel_nx   = nxt[2:0];
               cnt_nx   = DWELL_LD;
               state_nx = S_DWELL;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      en_nx   = (state_nx == S_DWELL);
      busy_nx = (state_nx != S_IDLE);
   end

endmodule

// File: tb/tb_select_scanner.sv
// tb/tb_select_scanner.sv - directed bench for select_scanner (GAP=0 and GAP=1 instances)
module tb_select_scanner;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start0, stop0, mode0, start1, stop1, mode1;
   logic [7:0] mask0, mask1;
   logic [2:0] sel0, sel1;
   logic       en0, busy0, done0, err0, en1, busy1, done1, err1;
   int         total = 0;
   int         passed = 0;
   logic [2:0] chs [3];

   always #5 clk = ~clk;

   select_scanner #(.DWELL(4), .GAP(0), .CW(8)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0), .mode(mode0), .mask(mask0),
      .sel(sel0), .en(en0), .busy(busy0), .done(done0), .err(err0));

   select_scanner #(.DWELL(4), .GAP(1), .CW(8)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .mode(mode1), .mask(mask1),
      .sel(sel1), .en(en1), .busy(busy1), .done(done1), .err(err1));

   wire [6:0] o0 = {sel0, en0, busy0, done0, err0};
   wire [6:0] o1 = {sel1, en1, busy1, done1, err1};

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   // vectors are {sel[2:0], en, busy, done, err}
   task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   initial begin
      chs = '{3'd2, 3'd5, 3'd7};
      rst_n = 1'b0;
      {start0, stop0, mode0, mask0} = '0;
      {start1, stop1, mode1, mask1} = '0;
      #2;
      chk("reset_u0", o0, 7'b000_0000);
      chk("reset_u1", o1, 7'b000_0000);
      step;
      step;
      rst_n = 1'b1;

      // continuous, GAP=0: 0,7,0,7,... then stop in the 2nd cycle of a dwell
      mask0 = 8'b1000_0001;
      mode0 = 1'b1;
      start0 = 1'b1;
      step;
      for (int c = 0; c < 18; c++) begin
         chk($sformatf("cont_%0d", c), o0, {((c / 4) % 2 == 1) ? 3'd7 : 3'd0, 4'b1100});
         if (c == 0) start0 = 1'b0;
         if (c == 17) stop0 = 1'b1;
         step;
      end
      chk("cont_stopped", o0, 7'b000_0000);
      stop0 = 1'b0;
      step;
      chk("cont_idle", o0, 7'b000_0000);

      // one-shot 2,5,7 with GAP=1; mask/start disturbed mid-scan
      mask1 = 8'b1010_0100;
      mode1 = 1'b0;
      start1 = 1'b1;
      step;
      for (int c = 0; c < 16; c++) begin
         if (c < 14)
            chk($sformatf("oneshot_%0d", c), o1, {chs[c / 5], (c % 5) < 4, 3'b100});
         else if (c == 14)
            chk("oneshot_done", o1, {3'd7, 4'b0010});
         else
            chk("oneshot_after", o1, {3'd7, 4'b0000});
         if (c == 0) start1 = 1'b0;
         if (c == 3) begin
            mask1 = 8'hFF;
            start1 = 1'b1;
         end
         if (c == 4) start1 = 1'b0;
         step;
      end

      // zero mask -> err pulse; start+stop together -> nothing
      mask1 = 8'h00;
      start1 = 1'b1;
      step;
      chk("err_pulse", o1, {3'd7, 4'b0001});
      start1 = 1'b0;
      step;
      chk("err_cleared", o1, {3'd7, 4'b0000});
      mask1 = 8'b1010_0100;
      start1 = 1'b1;
      stop1 = 1'b1;
      step;
      chk("start_stop", o1, {3'd7, 4'b0000});
      start1 = 1'b0;
      stop1 = 1'b0;
      step;
      chk("start_stop_idle", o1, {3'd7, 4'b0000});

      // asynchronous reset mid-dwell
      start1 = 1'b1;
      step;
      chk("pre_reset_dwell", o1, {3'd2, 4'b1100});
      start1 = 1'b0;
      step;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset_u1", o1, 7'b000_0000);
      chk("async_reset_u0", o0, 7'b000_0000);
      step;
      rst_n = 1'b1;

      // single-bit one-shot: no gap, done right after the dwell
      mask1 = 8'b0001_0000;
      start1 = 1'b1;
      step;
      for (int c = 0; c < 6; c++) begin
         if (c < 4)
            chk($sformatf("single_%0d", c), o1, {3'd4, 4'b1100});
         else if (c == 4)
            chk("single_done", o1, {3'd4, 4'b0010});
         else
            chk("single_after", o1, {3'd4, 4'b0000});
         if (c == 0) start1 = 1'b0;
         step;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
